// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC register bridge.
package gpmc_pkg;

  // Bus-side transaction state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_RD_DRIVE
  } gpmc_state_t;

  // Depth of the strobe synchronisers and of the matching addr/data/be pipeline.
  localparam int SYNC_STAGES = 2;

  // Read data returned when the register file never answers.
  localparam logic [15:0] GPMC_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/gpmc_sync.sv
// Multi-bit flop-chain synchroniser; resets to all ones because GPMC strobes idle high.
module gpmc_sync
  import gpmc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [SYNC_STAGES];

  // Shift the asynchronous pin values through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_stage[i] <= '1;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpmc_reg_bridge.sv
// GPMC asynchronous non-multiplexed target converted to a single-cycle-strobe register bus.
module gpmc_reg_bridge
  import gpmc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    RD_TIMEOUT = 64,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = GPMC_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gpmc_cs_n,
  input  logic                  gpmc_adv_n,
  input  logic                  gpmc_oe_n,
  input  logic                  gpmc_we_n,
  input  logic [1:0]            gpmc_be_n,
  input  logic [ADDR_WIDTH-1:0] gpmc_addr,
  input  logic [DATA_WIDTH-1:0] gpmc_data_i,
  output logic [DATA_WIDTH-1:0] gpmc_data_o,
  output logic                  gpmc_data_oe,
  output logic                  gpmc_wait,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  reg_wr_en,
  output logic [DATA_WIDTH-1:0] reg_wr_data,
  output logic [1:0]            reg_wr_be,
  output logic                  reg_rd_en,
  input  logic [DATA_WIDTH-1:0] reg_rd_data,
  input  logic                  reg_rd_valid,
  output logic [7:0]            err_count
);

  localparam int CNT_W = $clog2(RD_TIMEOUT) + 1;

  // Strobes: [3]=cs_n [2]=adv_n [1]=oe_n [0]=we_n
  logic [3:0] w_strb;
  logic [2:0] r_strb_prev;

  gpmc_sync #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({gpmc_cs_n, gpmc_adv_n, gpmc_oe_n, gpmc_we_n}),
    .o_q (w_strb)
  );

  logic w_cs_n, w_adv_n, w_oe_n, w_we_n;
  logic w_adv_rise, w_oe_fall, w_oe_rise, w_we_fall, w_we_rise;
  assign w_cs_n     = w_strb[3];
  assign w_adv_n    = w_strb[2];
  assign w_oe_n     = w_strb[1];
  assign w_we_n     = w_strb[0];
  assign w_adv_rise = w_adv_n & ~r_strb_prev[2];
  assign w_oe_fall  = ~w_oe_n & r_strb_prev[1];
  assign w_oe_rise  = w_oe_n & ~r_strb_prev[1];
  assign w_we_fall  = ~w_we_n & r_strb_prev[0];
  assign w_we_rise  = w_we_n & ~r_strb_prev[0];

  // Edge-detect stage on the synchronised strobes.
  always_ff @(posedge clk) begin
    if (rst) r_strb_prev <= '1;
    else     r_strb_prev <= w_strb[2:0];
  end

  // Address/data/byte-enable pipeline matched to the synchroniser depth.
  logic [ADDR_WIDTH-1:0] r_addr_pipe [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] r_data_pipe [SYNC_STAGES];
  logic [1:0]            r_be_pipe   [SYNC_STAGES];

  // Delay the bus values so they line up with the synchronised strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_addr_pipe[i] <= '0;
        r_data_pipe[i] <= '0;
        r_be_pipe[i]   <= '1;
      end
    end else begin
      r_addr_pipe[0] <= gpmc_addr;
      r_data_pipe[0] <= gpmc_data_i;
      r_be_pipe[0]   <= gpmc_be_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_addr_pipe[i] <= r_addr_pipe[i-1];
        r_data_pipe[i] <= r_data_pipe[i-1];
        r_be_pipe[i]   <= r_be_pipe[i-1];
      end
    end
  end

  gpmc_state_t           r_state, w_state_next;
  logic                  r_entered, w_entered_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic                  r_wr_en, w_wr_en_next;
  logic [DATA_WIDTH-1:0] r_wr_data, w_wr_data_next;
  logic [1:0]            r_wr_be, w_wr_be_next;
  logic                  r_rd_en, w_rd_en_next;
  logic [DATA_WIDTH-1:0] r_data_o, w_data_o_next;
  logic                  r_data_oe, w_data_oe_next;
  logic                  r_wait, w_wait_next;
  logic [7:0]            r_err_count, w_err_next;
  logic                  w_err_inc;

  // Next-state and registered-output logic; every output is a flop.
  always_comb begin
    w_state_next   = r_state;
    w_entered_next = 1'b0;
    w_cnt_next     = r_cnt;
    w_addr_next    = r_addr;
    w_wr_en_next   = 1'b0;
    w_wr_data_next = r_wr_data;
    w_wr_be_next   = r_wr_be;
    w_rd_en_next   = 1'b0;
    w_data_o_next  = r_data_o;
    w_data_oe_next = r_data_oe;
    w_wait_next    = r_wait;
    w_err_inc      = 1'b0;

    if (w_cs_n) begin
      // Deselect aborts anything in flight, including a write without a we_n rise.
      w_state_next   = ST_IDLE;
      w_data_oe_next = 1'b0;
      w_wait_next    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_next   = ST_ADDR;
          w_entered_next = 1'b1;
        end
        ST_ADDR: begin
          if (w_adv_rise || (r_entered && w_adv_n))
            w_addr_next = r_addr_pipe[SYNC_STAGES-1];
          if ((w_we_fall || w_oe_fall) && !w_we_n && !w_oe_n) begin
            w_err_inc = 1'b1;
          end else if (w_we_fall) begin
            w_state_next = ST_WRITE;
          end else if (w_oe_fall) begin
            w_state_next = ST_RD_REQ;
            w_rd_en_next = 1'b1;
            w_wait_next  = 1'b1;
            w_cnt_next   = '0;
          end
        end
        ST_WRITE: begin
          if (w_we_rise) begin
            w_wr_data_next = r_data_pipe[SYNC_STAGES-1];
            w_wr_be_next   = ~r_be_pipe[SYNC_STAGES-1];
            w_wr_en_next   = 1'b1;
            w_state_next   = ST_ADDR;
          end
        end
        ST_RD_REQ, ST_RD_WAIT: begin
          // Valid may coincide with the read strobe itself, so RD_REQ also listens.
          if (reg_rd_valid) begin
            w_data_o_next  = reg_rd_data;
            w_data_oe_next = 1'b1;
            w_wait_next    = 1'b0;
            w_state_next   = ST_RD_DRIVE;
          end else if (r_state == ST_RD_WAIT && r_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            w_data_o_next  = ERR_DATA;
            w_data_oe_next = 1'b1;
            w_wait_next    = 1'b0;
            w_err_inc      = 1'b1;
            w_state_next   = ST_RD_DRIVE;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
            w_state_next = ST_RD_WAIT;
          end
        end
        ST_RD_DRIVE: begin
          if (w_oe_rise) begin
            w_data_oe_next = 1'b0;
            w_state_next   = ST_ADDR;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end

    w_err_next = (w_err_inc && r_err_count != 8'hFF) ? r_err_count + 8'd1 : r_err_count;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_entered   <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wr_en     <= 1'b0;
      r_wr_data   <= '0;
      r_wr_be     <= '0;
      r_rd_en     <= 1'b0;
      r_data_o    <= '0;
      r_data_oe   <= 1'b0;
      r_wait      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_next;
      r_entered   <= w_entered_next;
      r_cnt       <= w_cnt_next;
      r_addr      <= w_addr_next;
      r_wr_en     <= w_wr_en_next;
      r_wr_data   <= w_wr_data_next;
      r_wr_be     <= w_wr_be_next;
      r_rd_en     <= w_rd_en_next;
      r_data_o    <= w_data_o_next;
      r_data_oe   <= w_data_oe_next;
      r_wait      <= w_wait_next;
      r_err_count <= w_err_next;
    end
  end

  assign gpmc_data_o  = r_data_o;
  assign gpmc_data_oe = r_data_oe;
  assign gpmc_wait    = r_wait;
  assign reg_addr     = r_addr;
  assign reg_wr_en    = r_wr_en;
  assign reg_wr_data  = r_wr_data;
  assign reg_wr_be    = r_wr_be;
  assign reg_rd_en    = r_rd_en;
  assign err_count    = r_err_count;

endmodule
